// File: rtl/a2d_pkg.sv
// Shared types and helpers for the scanning A2D SPI master.
package a2d_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP
  } a2d_state_e;

  // Widest frame the command builder can produce.
  localparam int MAX_FRAME_W = 32;

  // Half an SCLK period in clk cycles.
  function automatic int sclk_half(input int sclk_div);
    return sclk_div / 2;
  endfunction

  // Bits needed for a counter running 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Command word {2'b00, ch, zeros}, left-aligned in a FRAME_W-bit frame.
  function automatic logic [MAX_FRAME_W-1:0] build_cmd(input int frame_w, input int chnl_w,
                                                       input int ch);
    return MAX_FRAME_W'(ch) << (frame_w - 2 - chnl_w);
  endfunction

endpackage

// File: rtl/a2d_sclk_gen.sv
// SCLK divider: low for the first half of each period, high for the second.
// Idles high whenever it is not enabled.
module a2d_sclk_gen
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int H  = sclk_half(SCLK_DIV);
  localparam int CW = cnt_w(SCLK_DIV);

  logic [CW-1:0] cnt_q;

  // Phase counter restarts at 0 whenever the divider is disabled.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(SCLK_DIV - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // rise_stb marks the clk edge that drives SCLK high, fall_stb the one that drives it low.
  assign sclk     = !en || (cnt_q >= CW'(H));
  assign rise_stb = en && (cnt_q == CW'(H - 1));
  assign fall_stb = en && (cnt_q == CW'(SCLK_DIV - 1));

endmodule

// File: rtl/a2d_spi_scan.sv
// SPI master for the serial A2D: single conversions or one-pass channel-mask scans,
// each result tagged with its channel and announced by a one-cycle strobe.
module a2d_spi_scan
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV   = 32,
  parameter int FRAME_W    = 16,
  parameter int DATA_W     = 12,
  parameter int CHNL_W     = 3,
  parameter int INVERT_RES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   strt_cnv,
  input  logic [CHNL_W-1:0]      chnnl,
  input  logic                   scan_en,
  input  logic [(1<<CHNL_W)-1:0] scan_mask,
  output logic                   busy,
  output logic                   cnv_cmplt,
  output logic                   scan_done,
  output logic [DATA_W-1:0]      res,
  output logic [CHNL_W-1:0]      res_chnl,
  output logic                   a2d_SS_n,
  output logic                   SCLK,
  output logic                   MOSI,
  input  logic                   MISO
);

  localparam int H   = sclk_half(SCLK_DIV);
  localparam int NCH = 1 << CHNL_W;
  localparam int TW  = cnt_w(H);
  localparam int BW  = cnt_w(FRAME_W);

  a2d_state_e        state_q, state_d;
  logic [TW-1:0]     tmr_q;
  logic [BW-1:0]     bit_q;
  logic [CHNL_W-1:0] ch_q, ch_d;
  logic [NCH-1:0]    pend_q, pend_clr;
  logic              scan_q;
  logic [FRAME_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic              accept, load_frame, frame_done, last_bit;
  logic              fall_stb, rise_stb;

  // Lowest set bit of a channel mask (0 if none).
  function automatic logic [CHNL_W-1:0] lowest_set(input logic [NCH-1:0] m);
    lowest_set = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = CHNL_W'(i);
    end
  endfunction

  // The converter's data bits are optionally active-low.
  function automatic logic [DATA_W-1:0] fmt_res(input logic [DATA_W-1:0] raw);
    return (INVERT_RES != 0) ? ~raw : raw;
  endfunction

  a2d_sclk_gen #(
    .SCLK_DIV(SCLK_DIV)
  ) u_sclk (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q == ST_SHIFT),
    .sclk    (SCLK),
    .fall_stb(fall_stb),
    .rise_stb(rise_stb)
  );

  assign last_bit = (bit_q == BW'(FRAME_W - 1));
  assign pend_clr = pend_q & ~(NCH'(1) << ch_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, channel selection and pin outputs.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    accept     = 1'b0;
    load_frame = 1'b0;
    frame_done = 1'b0;
    busy       = (state_q != ST_IDLE);
    a2d_SS_n   = !((state_q == ST_SETUP) || (state_q == ST_SHIFT));
    MOSI       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // An empty scan mask is not a request.
        if (strt_cnv && (!scan_en || (scan_mask != '0))) begin
          accept     = 1'b1;
          load_frame = 1'b1;
          ch_d       = scan_en ? lowest_set(scan_mask) : chnnl;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        MOSI = tx_q[FRAME_W-1];
        if (tmr_q == TW'(H - 1)) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        MOSI = tx_q[FRAME_W-1];
        if (fall_stb && last_bit) begin
          frame_done = 1'b1;
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_q == TW'(H - 1)) begin
          if (scan_q && (pend_q != '0)) begin
            load_frame = 1'b1;
            ch_d       = lowest_set(pend_q);
            state_d    = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control: SETUP/GAP dwell timer, bit counter, latched channel and scan bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q  <= '0;
      bit_q  <= '0;
      ch_q   <= '0;
      pend_q <= '0;
      scan_q <= 1'b0;
    end else begin
      if (((state_q == ST_SETUP) || (state_q == ST_GAP)) && (state_d == state_q)) begin
        tmr_q <= tmr_q + TW'(1);
      end else begin
        tmr_q <= '0;
      end
      if (state_q != ST_SHIFT) begin
        bit_q <= '0;
      end else if (fall_stb && !last_bit) begin
        bit_q <= bit_q + BW'(1);
      end
      if (load_frame) ch_q <= ch_d;
      if (accept) begin
        scan_q <= scan_en;
        pend_q <= scan_en ? scan_mask : '0;
      end else if (frame_done) begin
        pend_q <= pend_clr;
      end
    end
  end

  // Data: command shifter (advances on every SCLK fall but the first) and MISO capture.
  // Only the last DATA_W received bits are kept; earlier ones fall off the top.
  always_ff @(posedge clk) begin
    if (load_frame) begin
      tx_q <= FRAME_W'(build_cmd(FRAME_W, CHNL_W, int'(ch_d)));
    end else if ((state_q == ST_SHIFT) && fall_stb && !last_bit) begin
      tx_q <= tx_q << 1;
    end
    if (rise_stb) rx_q <= {rx_q[DATA_W-2:0], MISO};
  end

  // Result registers and completion strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnv_cmplt <= 1'b0;
      scan_done <= 1'b0;
      res       <= '0;
      res_chnl  <= '0;
    end else begin
      cnv_cmplt <= frame_done;
      scan_done <= frame_done && scan_q && (pend_clr == '0);
      if (frame_done) begin
        res      <= fmt_res(rx_q);
        res_chnl <= ch_q;
      end
    end
  end

endmodule

// File: tb/tb_a2d_spi_scan.sv
// Scoreboard bench for a2d_spi_scan: default instance (A) and a fast non-inverting one (B).
module tb_a2d_spi_scan;

  typedef struct {
    logic [11:0] res;
    logic [2:0]  ch;
    logic        sd;
    int          cyc;
    logic [15:0] cmd;
    int          ss_start;
    int          ss_low;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  exp_t sb_a[$], sb_b[$];

  // DUT A signals
  logic        strt_cnv = 1'b0, scan_en = 1'b0, MISO;
  logic [2:0]  chnnl = '0;
  logic [7:0]  scan_mask = '0;
  logic        busy, cnv_cmplt, scan_done, a2d_SS_n, SCLK, MOSI;
  logic [11:0] res;
  logic [2:0]  res_chnl;
  // DUT B signals
  logic        strt_b = 1'b0, scan_en_b = 1'b0, miso_b;
  logic [2:0]  chnnl_b = '0;
  logic [7:0]  scan_mask_b = '0;
  logic        busy_b, cmplt_b, sdone_b, ss_n_b, sclk_b, mosi_b;
  logic [11:0] res_b;
  logic [2:0]  res_chnl_b;

  a2d_spi_scan dut_a (
    .clk(clk), .rst(rst), .strt_cnv(strt_cnv), .chnnl(chnnl), .scan_en(scan_en),
    .scan_mask(scan_mask), .busy(busy), .cnv_cmplt(cnv_cmplt), .scan_done(scan_done),
    .res(res), .res_chnl(res_chnl), .a2d_SS_n(a2d_SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO)
  );

  a2d_spi_scan #(.SCLK_DIV(4), .INVERT_RES(0)) dut_b (
    .clk(clk), .rst(rst), .strt_cnv(strt_b), .chnnl(chnnl_b), .scan_en(scan_en_b),
    .scan_mask(scan_mask_b), .busy(busy_b), .cnv_cmplt(cmplt_b), .scan_done(sdone_b),
    .res(res_b), .res_chnl(res_chnl_b), .a2d_SS_n(ss_n_b), .SCLK(sclk_b), .MOSI(mosi_b),
    .MISO(miso_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // A2D slave models: MSB-first frame, MISO advances on each SCLK fall after the first.
  logic [15:0] pat_a = '0, sr_a = '0, mosi_a = '0;
  logic [15:0] pat_b = '0, sr_b = '0, mosi_rx_b = '0;
  int nfall_a = 0, nfall_b = 0;
  assign MISO   = sr_a[15];
  assign miso_b = sr_b[15];

  always @(negedge a2d_SS_n) begin sr_a = pat_a; nfall_a = 0; mosi_a = '0; end
  always @(negedge SCLK) if (a2d_SS_n === 1'b0) begin
    if (nfall_a != 0) sr_a = sr_a << 1;
    nfall_a++;
  end
  always @(posedge SCLK) if (a2d_SS_n === 1'b0) mosi_a = {mosi_a[14:0], MOSI};

  always @(negedge ss_n_b) begin sr_b = pat_b; nfall_b = 0; mosi_rx_b = '0; end
  always @(negedge sclk_b) if (ss_n_b === 1'b0) begin
    if (nfall_b != 0) sr_b = sr_b << 1;
    nfall_b++;
  end
  always @(posedge sclk_b) if (ss_n_b === 1'b0) mosi_rx_b = {mosi_rx_b[14:0], mosi_b};

  // Monitor A: track SS_n window, pop and compare on every completion.
  logic ss_prev_a = 1'b1;
  int   ss_start_a = 0, ss_low_a = 0;
  always @(negedge clk) begin
    exp_t e;
    if (a2d_SS_n === 1'b0 && ss_prev_a === 1'b1) begin ss_start_a = cyc; ss_low_a = 0; end
    if (a2d_SS_n === 1'b0) ss_low_a++;
    ss_prev_a = a2d_SS_n;
    if (cnv_cmplt === 1'b1) begin
      chk("a_cmplt_expected", 32'(sb_a.size() != 0), 1);
      if (sb_a.size() != 0) begin
        e = sb_a.pop_front();
        chk("a_res", 32'(res), 32'(e.res));
        chk("a_res_chnl", 32'(res_chnl), 32'(e.ch));
        chk("a_scan_done", 32'(scan_done), 32'(e.sd));
        chk("a_cmplt_cycle", cyc, e.cyc);
        chk("a_mosi_frame", 32'(mosi_a), 32'(e.cmd));
        chk("a_ss_start", ss_start_a, e.ss_start);
        chk("a_ss_low", ss_low_a, e.ss_low);
      end
    end
  end

  // Monitor B: same, plus SCLK period measurement inside the frame.
  logic ss_prev_b = 1'b1, sclk_prev_b = 1'b1;
  int   ss_start_b = 0, ss_low_b = 0, last_rise_b = -1, per_bad_b = 0, per_n_b = 0;
  always @(negedge clk) begin
    exp_t e;
    if (ss_n_b === 1'b0 && ss_prev_b === 1'b1) begin
      ss_start_b = cyc; ss_low_b = 0; last_rise_b = -1;
    end
    if (ss_n_b === 1'b0) begin
      ss_low_b++;
      if (sclk_b === 1'b1 && sclk_prev_b === 1'b0) begin
        if (last_rise_b >= 0) begin
          per_n_b++;
          if (cyc - last_rise_b != 4) per_bad_b++;
        end
        last_rise_b = cyc;
      end
    end
    ss_prev_b   = ss_n_b;
    sclk_prev_b = sclk_b;
    if (cmplt_b === 1'b1) begin
      chk("b_cmplt_expected", 32'(sb_b.size() != 0), 1);
      if (sb_b.size() != 0) begin
        e = sb_b.pop_front();
        chk("b_res", 32'(res_b), 32'(e.res));
        chk("b_res_chnl", 32'(res_chnl_b), 32'(e.ch));
        chk("b_cmplt_cycle", cyc, e.cyc);
        chk("b_mosi_frame", 32'(mosi_rx_b), 32'(e.cmd));
        chk("b_ss_start", ss_start_b, e.ss_start);
        chk("b_ss_low", ss_low_b, e.ss_low);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller is positioned #1 after a posedge; t0 is the acceptance cycle ("cycle 0").
  task automatic start_a(input logic [2:0] ch, input logic scan, input logic [7:0] mask,
                         output int t0);
    chnnl = ch; scan_en = scan; scan_mask = mask; strt_cnv = 1'b1;
    t0 = cyc;
    step();
    strt_cnv = 1'b0;
  endtask

  task automatic push_a(input logic [11:0] r, input logic [2:0] ch, input logic sd,
                        input int t_cmplt, input logic [15:0] cmd, input int t_ss);
    exp_t e;
    e.res = r; e.ch = ch; e.sd = sd; e.cyc = t_cmplt; e.cmd = cmd;
    e.ss_start = t_ss; e.ss_low = 528;
    sb_a.push_back(e);
  endtask

  task automatic wait_busy_low(input int limit, output int fall);
    fall = -1;
    for (int i = 0; i < limit; i++) begin
      if (busy === 1'b0) begin fall = cyc; break; end
      step();
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (sb_a.size() == 0 && sb_b.size() == 0 && busy === 1'b0 && busy_b === 1'b0) break;
      step();
    end
    chk(name, 32'(sb_a.size() + sb_b.size()), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, fall, ss_low_cnt, busy_cnt;
    exp_t e;

    // Reset values
    rst = 1'b1;
    repeat (3) step();
    chk("rst_ss_n", 32'(a2d_SS_n), 1);
    chk("rst_sclk", 32'(SCLK), 1);
    chk("rst_mosi", 32'(MOSI), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmplt", 32'(cnv_cmplt), 0);
    chk("rst_scan_done", 32'(scan_done), 0);
    chk("rst_res", 32'(res), 0);
    chk("rst_res_chnl", 32'(res_chnl), 0);
    chk("rst_b_ss_sclk", 32'({ss_n_b, sclk_b, busy_b, res_b}), 32'({3'b110, 12'h000}));
    rst = 1'b0;
    step();

    // B: SCLK_DIV=4, no inversion, ch=1, slave returns 16'h0ABC
    pat_b = 16'h0ABC;
    chnnl_b = 3'd1; strt_b = 1'b1; t0 = cyc;
    e.res = 12'hABC; e.ch = 3'd1; e.sd = 1'b0; e.cyc = t0 + 67; e.cmd = 16'h0800;
    e.ss_start = t0 + 1; e.ss_low = 66;
    sb_b.push_back(e);
    step();
    strt_b = 1'b0;
    wait_idle("b_drain", 300);
    chk("b_sclk_periods", per_n_b, 15);
    chk("b_sclk_period_bad", per_bad_b, 0);

    // A: single ch=5, slave 16'hF5A3, with a start request and input churn mid-frame
    pat_a = 16'hF5A3;
    start_a(3'd5, 1'b0, 8'h00, t0);
    push_a(12'hA5C, 3'd5, 1'b0, t0 + 529, 16'h2800, t0 + 1);
    repeat (99) step();
    chnnl = 3'd2; scan_en = 1'b1; scan_mask = 8'hFF; strt_cnv = 1'b1;
    step();
    strt_cnv = 1'b0;
    wait_busy_low(1000, fall);
    chk("single_busy_fall", fall, t0 + 545);

    // Start on the first idle cycle after a frame
    start_a(3'd2, 1'b0, 8'h00, t1);
    push_a(12'hA5C, 3'd2, 1'b0, t1 + 529, 16'h1000, t1 + 1);
    wait_busy_low(1000, fall);
    chk("restart_busy_fall", fall, t1 + 545);
    wait_idle("single_drain", 100);

    // Scan over channels 0, 2, 7; slave 16'h1234 -> ~12'h234
    pat_a = 16'h1234;
    step();
    start_a(3'd4, 1'b1, 8'b1000_0101, t0);
    push_a(12'hDCB, 3'd0, 1'b0, t0 + 529,        16'h0000, t0 + 1);
    push_a(12'hDCB, 3'd2, 1'b0, t0 + 529 + 544,  16'h1000, t0 + 1 + 544);
    push_a(12'hDCB, 3'd7, 1'b1, t0 + 529 + 1088, 16'h3800, t0 + 1 + 1088);
    wait_busy_low(2500, fall);
    chk("scan_busy_fall", fall, t0 + 3 * 544 + 1);
    wait_idle("scan_drain", 100);

    // Scan with empty mask: ignored
    start_a(3'd0, 1'b1, 8'h00, t0);
    ss_low_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      if (a2d_SS_n !== 1'b1) ss_low_cnt++;
      if (busy !== 1'b0) busy_cnt++;
      step();
    end
    chk("mask0_ss_low_cycles", ss_low_cnt, 0);
    chk("mask0_busy_cycles", busy_cnt, 0);
    scan_en = 1'b0; scan_mask = 8'h00;

    // Reset at cycle 200 of a frame
    pat_a = 16'h0F0F;
    start_a(3'd3, 1'b0, 8'h00, t0);
    repeat (199) step();
    chk("pre_rst_ss_low", 32'(a2d_SS_n), 0);
    rst = 1'b1;
    step();
    chk("midrst_ss_n", 32'(a2d_SS_n), 1);
    chk("midrst_sclk", 32'(SCLK), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_cmplt", 32'(cnv_cmplt), 0);
    chk("midrst_res", 32'(res), 0);
    rst = 1'b0;
    repeat (3) step();
    start_a(3'd6, 1'b0, 8'h00, t0);
    push_a(12'h0F0, 3'd6, 1'b0, t0 + 529, 16'h3000, t0 + 1);
    wait_idle("post_rst_drain", 1000);

    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
